// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard / branch controller.
// Holds the data-processing opcodes that change source/destination use,
// the coarse instruction class, the ARM condition codes and the layout of
// one in-flight tracking slot.
package pipe_ctrl_unit_pkg;

    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    typedef enum logic [1:0] {
        IT_NOP,
        IT_DP,
        IT_MEM,
        IT_BR
    } instr_type_e;

    // has_rd separates "occupies the slot" from "writes a register"
    // (compares and stores are valid but produce nothing to wait on).
    typedef struct packed {
        logic        valid;
        logic        has_rd;
        logic [3:0]  rd;
        logic        is_load;
        logic        is_branch;
        logic [3:0]  cond;
        logic [23:0] imm24;
        logic [31:0] pc;
    } slot_t;

    // The all-zero word is the pipeline NOP even though it would otherwise
    // decode as a data-processing AND.
    function automatic instr_type_e decode_type(input logic [31:0] ins);
        instr_type_e t;
        t = IT_NOP;
        if (ins != 32'h0) begin
            case (ins[27:26])
                2'b00:   t = IT_DP;
                2'b01:   t = IT_MEM;
                2'b10:   t = IT_BR;
                default: t = IT_NOP;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_cond_check.sv
// ARM condition-code evaluator, purely combinational.
// Ports:
//   i_cond  condition field [31:28] of an instruction
//   i_nzcv  status flags {N,Z,C,V}
//   o_pass  1 when the instruction should execute (NV never passes)
module pipe_ctrl_unit_cond_check
    import pipe_ctrl_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);
    logic w_n, w_z, w_c, w_v;

    assign w_n = i_nzcv[3];
    assign w_z = i_nzcv[2];
    assign w_c = i_nzcv[1];
    assign w_v = i_nzcv[0];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            CC_EQ:   o_pass = w_z;
            CC_NE:   o_pass = ~w_z;
            CC_CS:   o_pass = w_c;
            CC_CC:   o_pass = ~w_c;
            CC_MI:   o_pass = w_n;
            CC_PL:   o_pass = ~w_n;
            CC_VS:   o_pass = w_v;
            CC_VC:   o_pass = ~w_v;
            CC_HI:   o_pass = w_c & ~w_z;
            CC_LS:   o_pass = ~w_c | w_z;
            CC_GE:   o_pass = (w_n == w_v);
            CC_LT:   o_pass = (w_n != w_v);
            CC_GT:   o_pass = ~w_z & (w_n == w_v);
            CC_LE:   o_pass = w_z | (w_n != w_v);
            CC_AL:   o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Hazard and branch-resolution controller for the 5-stage ARM core.
// Decodes the instruction in decode, tracks the EX (slot p0) and MEM
// (slot p1) occupants, stalls fetch/decode on RAW hazards, resolves
// branches sitting in EX and counts stall and flush events (saturating).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instruction, pc decode-stage instruction and its pc (fetch + 4)
//   status_nzcv     committed {N,Z,C,V}
//   freeze          hold pc and fetch/decode register
//   flush           clear fetch/decode and decode/execute registers
//   branch_taken    redirect fetch to branch_addr
//   branch_addr     branch target, 0 when no branch is taken
//   stall_count     freeze cycles seen (saturating)
//   flush_count     taken branches seen (saturating)
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter bit FORWARDING_EN = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic [31:0]      pc,
    input  logic [3:0]       status_nzcv,
    output logic             freeze,
    output logic             flush,
    output logic             branch_taken,
    output logic [31:0]      branch_addr,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    slot_t            r_slot_p0;
    slot_t            r_slot_p1;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    instr_type_e w_type;
    logic [3:0]  w_op, w_rn, w_rm, w_rd;
    logic        w_use_rn, w_use_rm, w_use_rd, w_has_rd, w_is_load;
    logic        w_hit_p0, w_hit_p1, w_hazard;
    logic        w_cond_pass, w_taken, w_issue;
    logic [31:0] w_offset;
    slot_t       w_dec_slot;
    logic        w_unused_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic src_hit(input logic [3:0] src, input slot_t s);
        return s.valid & s.has_rd & (s.rd == src);
    endfunction

    // ---- decode stage: source / destination usage ----
    assign w_type = decode_type(instruction);
    assign w_op   = instruction[24:21];
    assign w_rn   = instruction[19:16];
    assign w_rd   = instruction[15:12];
    assign w_rm   = instruction[3:0];

    always_comb begin
        w_use_rn  = 1'b0;
        w_use_rm  = 1'b0;
        w_use_rd  = 1'b0;
        w_has_rd  = 1'b0;
        w_is_load = 1'b0;
        case (w_type)
            IT_DP: begin
                w_use_rn = (w_op != OP_MOV) && (w_op != OP_MVN);
                w_use_rm = ~instruction[25];
                w_has_rd = (w_op != OP_TST) && (w_op != OP_TEQ) &&
                           (w_op != OP_CMP) && (w_op != OP_CMN);
            end
            IT_MEM: begin
                w_use_rn  = 1'b1;
                w_has_rd  = instruction[20];
                w_is_load = instruction[20];
                // a store reads Rd as its data operand
                w_use_rd  = ~instruction[20];
            end
            default: ;
        endcase
    end

    // With forwarding only a load still in EX cannot supply its result.
    assign w_hit_p0 = (w_use_rn & src_hit(w_rn, r_slot_p0)) |
                      (w_use_rm & src_hit(w_rm, r_slot_p0)) |
                      (w_use_rd & src_hit(w_rd, r_slot_p0));
    assign w_hit_p1 = (w_use_rn & src_hit(w_rn, r_slot_p1)) |
                      (w_use_rm & src_hit(w_rm, r_slot_p1)) |
                      (w_use_rd & src_hit(w_rd, r_slot_p1));
    assign w_hazard = FORWARDING_EN ? (w_hit_p0 & r_slot_p0.is_load)
                                    : (w_hit_p0 | w_hit_p1);

    // ---- execute stage (slot p0): branch resolution ----
    pipe_ctrl_unit_cond_check u_cond_check (
        .i_cond (r_slot_p0.cond),
        .i_nzcv (status_nzcv),
        .o_pass (w_cond_pass)
    );

    assign w_taken  = r_slot_p0.valid & r_slot_p0.is_branch & w_cond_pass;
    assign w_offset = {{6{r_slot_p0.imm24[23]}}, r_slot_p0.imm24, 2'b00};

    // A taken branch squashes decode, so it also overrides any stall.
    assign flush        = w_taken;
    assign branch_taken = w_taken;
    assign freeze       = w_hazard & ~w_taken;
    assign branch_addr  = w_taken ? (r_slot_p0.pc + 32'd4 + w_offset) : 32'd0;
    assign w_issue      = ~freeze & ~flush;

    always_comb begin
        w_dec_slot           = '0;
        w_dec_slot.valid     = w_issue;
        w_dec_slot.has_rd    = w_has_rd;
        w_dec_slot.rd        = w_rd;
        w_dec_slot.is_load   = w_is_load;
        w_dec_slot.is_branch = (w_type == IT_BR);
        w_dec_slot.cond      = instruction[31:28];
        w_dec_slot.imm24     = instruction[23:0];
        w_dec_slot.pc        = pc;
    end

    // ---- slot advance: decode -> p0 (EX) -> p1 (MEM) ----
    always_ff @(posedge clk) begin
        r_slot_p0 <= w_dec_slot;
        r_slot_p1 <= r_slot_p0;
        if (rst) begin
            r_slot_p0.valid <= 1'b0;
            r_slot_p1.valid <= 1'b0;
        end
    end

    // ---- event counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (freeze)  r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_taken) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

    // MEM slot only needs its destination fields; the rest rides along.
    assign w_unused_p1 = ^{r_slot_p1.is_load, r_slot_p1.is_branch,
                           r_slot_p1.cond, r_slot_p1.imm24, r_slot_p1.pc};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

    typedef logic [66:0]       obs_t;   // {freeze,flush,taken,addr,stall16,flush16}
    typedef logic [2:0][66:0]  obs3_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, pc;
    logic [3:0]  nzcv;

    logic        f0, fl0, bt0, f1, fl1, bt1, f2, fl2, bt2;
    logic [31:0] ba0, ba1, ba2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.FORWARDING_EN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .status_nzcv(nzcv),
        .freeze(f0), .flush(fl0), .branch_taken(bt0), .branch_addr(ba0),
        .stall_count(sc0), .flush_count(fc0));
    pipe_ctrl_unit #(.FORWARDING_EN(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .status_nzcv(nzcv),
        .freeze(f1), .flush(fl1), .branch_taken(bt1), .branch_addr(ba1),
        .stall_count(sc1), .flush_count(fc1));
    pipe_ctrl_unit #(.FORWARDING_EN(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .status_nzcv(nzcv),
        .freeze(f2), .flush(fl2), .branch_taken(bt2), .branch_addr(ba2),
        .stall_count(sc2), .flush_count(fc2));

    obs_t a0, a1, a2;
    assign a0 = {f0, fl0, bt0, ba0, sc0, fc0};
    assign a1 = {f1, fl1, bt1, ba1, sc1, fc1};
    assign a2 = {f2, fl2, bt2, ba2, 14'd0, sc2, 14'd0, fc2};

    // Reference model: per instance, the last two issued instruction words
    // (index 0 = one cycle ago, 1 = two cycles ago) plus event counts.
    logic [31:0] h_w [3][2];
    logic [31:0] h_p [3][2];
    bit          h_v [3][2];
    int          scnt [3];
    int          fcnt [3];
    bit          m_frz [3];
    bit          m_tak [3];
    int          cmax [3] = '{65535, 65535, 3};
    bit          fwd  [3] = '{1'b0, 1'b1, 1'b0};

    obs3_t sb [$];
    obs3_t m_e;

    function automatic int dest_of(input logic [31:0] w);
        if (w == 32'h0) return -1;
        case (w[27:26])
            2'b00:   return (w[24:21] inside {4'd8, 4'd9, 4'd10, 4'd11}) ? -1 : int'(w[15:12]);
            2'b01:   return w[20] ? int'(w[15:12]) : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] srcs_of(input logic [31:0] w);
        logic [15:0] m;
        m = '0;
        if (w != 32'h0) begin
            if (w[27:26] == 2'b00) begin
                if (!(w[24:21] inside {4'd13, 4'd15})) m[w[19:16]] = 1'b1;
                if (!w[25]) m[w[3:0]] = 1'b1;
            end else if (w[27:26] == 2'b01) begin
                m[w[19:16]] = 1'b1;
                if (!w[20]) m[w[15:12]] = 1'b1;
            end
        end
        return m;
    endfunction

    // ARM rule: pairs of codes test one predicate, odd code is its inverse.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: return (c == 4'hE);
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] w, input logic [31:0] p);
        int off;
        off = int'(w[23:0]);
        if (w[23]) off = off - 32'h0100_0000;
        return p + 32'd4 + 32'(off * 4);
    endfunction

    task automatic drive(input logic r, input logic [31:0] w, input logic [31:0] p,
                         input logic [3:0] f);
        obs3_t e;
        rst = r; instruction = w; pc = p; nzcv = f;
        for (int k = 0; k < 3; k++) begin
            int d0, d1;
            bit hit0, hit1, ld0, hz;
            logic [15:0] sm;
            logic [31:0] addr;
            sm   = srcs_of(w);
            d0   = h_v[k][0] ? dest_of(h_w[k][0]) : -1;
            d1   = h_v[k][1] ? dest_of(h_w[k][1]) : -1;
            hit0 = (d0 >= 0) && sm[d0];
            hit1 = (d1 >= 0) && sm[d1];
            ld0  = h_v[k][0] && (h_w[k][0][27:26] == 2'b01) && h_w[k][0][20];
            hz   = fwd[k] ? (hit0 && ld0) : (hit0 || hit1);
            m_tak[k] = h_v[k][0] && (h_w[k][0][27:26] == 2'b10) &&
                       cond_ok(h_w[k][0][31:28], f);
            m_frz[k] = hz && !m_tak[k];
            addr = m_tak[k] ? target(h_w[k][0], h_p[k][0]) : 32'd0;
            e[k] = {m_frz[k], m_tak[k], m_tak[k], addr, 16'(scnt[k]), 16'(fcnt[k])};
        end
        if (!r) sb.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                h_v[k][0] = 1'b0; h_v[k][1] = 1'b0;
                scnt[k] = 0; fcnt[k] = 0;
            end else begin
                h_w[k][1] = h_w[k][0]; h_p[k][1] = h_p[k][0]; h_v[k][1] = h_v[k][0];
                h_w[k][0] = instruction; h_p[k][0] = pc;
                h_v[k][0] = !m_frz[k] && !m_tak[k];
                if (m_frz[k] && scnt[k] < cmax[k]) scnt[k]++;
                if (m_tak[k] && fcnt[k] < cmax[k]) fcnt[k]++;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] p, input int sel);
        int n;
        n = 0;
        do begin
            drive(1'b0, w, p, 4'h0);
            tick();
            n++;
        end while (m_frz[sel] && n < 8);
    endtask

    task automatic do_reset();
        drive(1'b1, 32'h0, 32'h0, 4'h0); tick();
        drive(1'b1, 32'h0, 32'h0, 4'h0); tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic sb_cmp(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL sb_%s t=%0t got frz=%b fl=%b bt=%b addr=%h sc=%0d fc=%0d want frz=%b fl=%b bt=%b addr=%h sc=%0d fc=%0d",
                     nm, $time, act[66], act[65], act[64], act[63:32], act[31:16], act[15:0],
                     exp[66], exp[65], exp[64], exp[63:32], exp[31:16], exp[15:0]);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            sb_cmp("fwd0", a0, m_e[0]);
            sb_cmp("fwd1", a1, m_e[1]);
            sb_cmp("cnt2", a2, m_e[2]);
        end
    end

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w = 32'h0;
            1, 2: begin
                w[31:28] = 4'hE; w[27:26] = 2'b00;
                w[19:16] = 4'($urandom_range(0, 3));
                w[15:12] = 4'($urandom_range(0, 3));
                w[3:0]   = 4'($urandom_range(0, 3));
            end
            3: begin
                w[31:28] = 4'hE; w[27:26] = 2'b01;
                w[19:16] = 4'($urandom_range(0, 3));
                w[15:12] = 4'($urandom_range(0, 3));
            end
            4: w[27:26] = 2'b10;
            default: begin w[31:28] = 4'hE; w[27:26] = 2'b11; end
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] w, p;
        bit          hold, r;
        rst = 1'b1; instruction = 32'h0; pc = 32'h0; nzcv = 4'h0;

        // reset and NOPs
        do_reset();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("rst_freeze", {31'd0, f0}, 32'd0);
        chk("rst_stall", {16'd0, sc0}, 32'd0);
        chk("rst_addr", ba0, 32'd0);
        tick();
        nops(2);

        // RAW without forwarding, plain producer with forwarding
        issue(32'hE0821003, 32'h8, 0);
        issue(32'hE0414005, 32'hC, 0);
        nops(2);
        chk("raw_stall_nofwd", {16'd0, sc0}, 32'd2);
        chk("raw_stall_fwd", {16'd0, sc1}, 32'd0);

        // load-use with forwarding
        do_reset();
        issue(32'hE5921000, 32'h8, 1);
        issue(32'hE0813001, 32'hC, 1);
        nops(2);
        chk("loaduse_stall", {16'd0, sc1}, 32'd1);

        // taken branch
        do_reset();
        drive(1'b0, 32'hEA000002, 32'h14, 4'h0); tick();
        drive(1'b0, 32'h0, 32'h18, 4'h0);
        chk("br_taken", {31'd0, bt0}, 32'd1);
        chk("br_flush", {31'd0, fl0}, 32'd1);
        chk("br_addr", ba0, 32'h20);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("br_fcnt", {16'd0, fc0}, 32'd1);
        tick();

        // conditional branch, not taken then taken
        drive(1'b0, 32'h0A000002, 32'h14, 4'h0); tick();
        drive(1'b0, 32'h0, 32'h18, 4'h0);
        chk("beq_nt", {30'd0, bt0, fl0}, 32'd0);
        tick();
        drive(1'b0, 32'h0A000002, 32'h14, 4'h4); tick();
        drive(1'b0, 32'h0, 32'h18, 4'h4);
        chk("beq_t", {31'd0, bt0}, 32'd1);
        tick();

        // branch vs hazard priority
        do_reset();
        issue(32'hE0821003, 32'h8, 0);
        drive(1'b0, 32'hEA000002, 32'h10, 4'h0); tick();
        drive(1'b0, 32'hE0414005, 32'h14, 4'h0);
        chk("prio_flush", {31'd0, fl0}, 32'd1);
        chk("prio_freeze", {31'd0, f0}, 32'd0);
        tick();
        nops(2);

        // negative offset
        drive(1'b0, 32'hEAFFFFFE, 32'h14, 4'h0); tick();
        drive(1'b0, 32'h0, 32'h18, 4'h0);
        chk("neg_addr", ba0, 32'h10);
        tick();

        // reset discards a pending branch
        drive(1'b0, 32'hEA000002, 32'h14, 4'h0); tick();
        drive(1'b1, 32'h0, 32'h0, 4'h0); tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("rst_branch", {31'd0, bt0}, 32'd0);
        tick();

        // stall counter saturation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(32'hE0821003, 32'h8, 0);
            issue(32'hE0414005, 32'hC, 0);
        end
        nops(2);
        chk("sat_stall_cnt2", {30'd0, sc2}, 32'd3);
        chk("sat_stall_cnt16", {16'd0, sc0}, 32'd6);

        // randomized traffic against the model
        do_reset();
        hold = 1'b0; p = 32'h100; w = 32'h0;
        for (int i = 0; i < 500; i++) begin
            if (!hold) begin
                w = rnd_instr();
                p = p + 32'd4;
            end
            r = ($urandom_range(0, 60) == 0);
            drive(r, w, p, 4'($urandom_range(0, 15)));
            tick();
            hold = m_frz[0] && !r;
        end
        nops(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
